// File: rtl/vr_sa_pkg.sv
// ---------------------------------------------------------------------------
// vr_sa_pkg
// Shared definitions for the router switch allocator:
//   NUM_PORTS_DEF / NUM_VCS_DEF : default router geometry (4 ports, 4 VCs)
//   PORT_W / VC_W               : index widths derived from the defaults
//   sa_lock_t                   : per-output wormhole lock entry
//                                 {valid, in_idx, vc_idx}
// The lock entry is sized from the package defaults. A build that enables
// the packet lock with a larger geometry must raise the defaults here too.
// ---------------------------------------------------------------------------
package vr_sa_pkg;

  localparam int NUM_PORTS_DEF = 4;
  localparam int NUM_VCS_DEF   = 4;

  localparam int PORT_W = (NUM_PORTS_DEF > 1) ? $clog2(NUM_PORTS_DEF) : 1;
  localparam int VC_W   = (NUM_VCS_DEF > 1) ? $clog2(NUM_VCS_DEF) : 1;

  typedef struct packed {
    logic              valid;
    logic [PORT_W-1:0] in_idx;
    logic [VC_W-1:0]   vc_idx;
  } sa_lock_t;

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Scans req starting at index ptr
// (modulo N) and returns the first requester found.
// Ports:
//   req       [N-1:0] : request vector
//   ptr       [W-1:0] : highest-priority index for this cycle
//   grant     [N-1:0] : one-hot winner (all zero when nothing requests)
//   grant_idx [W-1:0] : binary index of the winner (0 when nothing requests)
// The pointer register is owned by the caller, so the caller decides when a
// pick counts as a real grant and advances the pointer.
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx
);

  always_comb begin
    int   idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    for (int k = 0; k < N; k++) begin
      // Modulo keeps the scan in range even if ptr exceeds N-1 when N is
      // not a power of two.
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = W'(idx);
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// ---------------------------------------------------------------------------
// switch_allocator
// Separable input-first round-robin switch allocator for the router
// crossbar. Grants are combinational from the requests and the registered
// round-robin pointers (zero latency).
//   Stage 1 (per input)  : choose one eligible VC, rotating from in_ptr[i].
//   Stage 2 (per output) : choose one stage-1 winner, rotating from out_ptr[o].
// Ports:
//   clk        : router clock, state updates on posedge
//   reset      : asynchronous, active-high; also blanks all grant outputs
//   req_vc     [P][V]    : VC v of input i holds a flit ready to traverse
//   req_port   [P][V][P] : one-hot target output of the head flit of (i,v)
//   req_tail   [P][V]    : flit at (i,v) is a tail (packet lock build only)
//   out_ready  [P]       : output o can accept a flit this cycle
//   vc_mapping [P][P]    : per input, one-hot granted output (crossbar select)
//   valid      [P]       : per input, a grant was issued this cycle
//   grant_vc   [P][V]    : per input, one-hot VC to dequeue this cycle
// Configuration:
//   SA_PKT_LOCK_EN defined   : wormhole lock. A non-tail grant of (i,v) to o
//                             reserves o for (i,v) until its tail is granted,
//                             and pins input i's stage 1 to VC v meanwhile.
//   SA_PKT_LOCK_EN undefined: every flit is arbitrated on its own and
//                             req_tail is ignored.
// ---------------------------------------------------------------------------
module switch_allocator
  import vr_sa_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int NUM_VCS   = NUM_VCS_DEF
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [NUM_PORTS-1:0][NUM_VCS-1:0]                req_vc,
  input  logic [NUM_PORTS-1:0][NUM_VCS-1:0][NUM_PORTS-1:0] req_port,
  input  logic [NUM_PORTS-1:0][NUM_VCS-1:0]                req_tail,
  input  logic [NUM_PORTS-1:0]                             out_ready,
  output logic [NUM_PORTS-1:0][NUM_PORTS-1:0]              vc_mapping,
  output logic [NUM_PORTS-1:0]                             valid,
  output logic [NUM_PORTS-1:0][NUM_VCS-1:0]                grant_vc
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int VW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;

  // Round-robin pointers
  logic [VW-1:0] in_ptr_reg   [NUM_PORTS];
  logic [VW-1:0] in_ptr_next  [NUM_PORTS];
  logic [PW-1:0] out_ptr_reg  [NUM_PORTS];
  logic [PW-1:0] out_ptr_next [NUM_PORTS];

  // Lock-derived masks: port_block[i][o] = output o is reserved for some
  // other input; vc_allow[i][v] = VC v of input i may compete in stage 1.
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] port_block;
  logic [NUM_PORTS-1:0][NUM_VCS-1:0]   vc_allow;

  // Stage 1 (indexed by input)
  logic [NUM_PORTS-1:0][NUM_VCS-1:0]   eligible;
  logic [NUM_PORTS-1:0][NUM_VCS-1:0]   s1_grant;
  logic [VW-1:0]                       s1_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0]                s1_valid;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] s1_port;

  // Stage 2 (indexed by output)
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] s2_req;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] s2_grant;
  logic [PW-1:0]                       s2_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0]                s2_valid;

  // Final match (indexed by input), before reset blanking
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] map_raw;
  logic [NUM_PORTS-1:0]                grant_raw;

`ifdef SA_PKT_LOCK_EN
  // -------------------------------------------------------------------------
  // Wormhole lock state, one entry per output
  // -------------------------------------------------------------------------
  sa_lock_t lock_reg  [NUM_PORTS];
  sa_lock_t lock_next [NUM_PORTS];

  always_comb begin
    port_block = '0;
    vc_allow   = '1;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (lock_reg[o].valid) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (int'(lock_reg[o].in_idx) == i) begin
            // Owner keeps competing only with the VC that holds the packet.
            vc_allow[i]                     = '0;
            vc_allow[i][lock_reg[o].vc_idx] = 1'b1;
          end else begin
            port_block[i][o] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      lock_next[o] = lock_reg[o];
      if (s2_valid[o]) begin
        if (req_tail[s2_idx[o]][s1_idx[s2_idx[o]]]) begin
          lock_next[o].valid = 1'b0;
        end else begin
          lock_next[o].valid  = 1'b1;
          lock_next[o].in_idx = PORT_W'(s2_idx[o]);
          lock_next[o].vc_idx = VC_W'(s1_idx[s2_idx[o]]);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        lock_reg[o] <= '0;
      end
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        lock_reg[o] <= lock_next[o];
      end
    end
  end
`else
  // No packet lock: every VC is free to compete for every ready output.
  assign port_block = '0;
  assign vc_allow   = '1;

  logic unused_tail;
  assign unused_tail = ^req_tail;
`endif

  // -------------------------------------------------------------------------
  // Stage 1 eligibility: a VC competes only if its target output is ready
  // and not reserved by another input's packet, so a blocked head flit
  // never shadows a sibling VC that could make progress.
  // -------------------------------------------------------------------------
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        eligible[i][v] = req_vc[i][v] && vc_allow[i][v] &&
                         (|(req_port[i][v] & out_ready & ~port_block[i]));
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_stage1
      rr_arbiter #(.N(NUM_VCS)) u_in_arb (
        .req       (eligible[gi]),
        .ptr       (in_ptr_reg[gi]),
        .grant     (s1_grant[gi]),
        .grant_idx (s1_idx[gi])
      );

      assign s1_valid[gi] = |eligible[gi];
      assign s1_port[gi]  = s1_valid[gi] ?
                            (req_port[gi][s1_idx[gi]] & out_ready & ~port_block[gi]) :
                            '0;
    end
  endgenerate

  // Transpose stage-1 targets into per-output candidate vectors.
  always_comb begin
    s2_req = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        s2_req[o][i] = s1_port[i][o];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_stage2
      rr_arbiter #(.N(NUM_PORTS)) u_out_arb (
        .req       (s2_req[gi]),
        .ptr       (out_ptr_reg[gi]),
        .grant     (s2_grant[gi]),
        .grant_idx (s2_idx[gi])
      );

      assign s2_valid[gi] = |s2_req[gi];
    end
  endgenerate

  // Transpose stage-2 winners back to per-input rows.
  always_comb begin
    map_raw   = '0;
    grant_raw = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        map_raw[i][o] = s2_grant[o][i];
      end
      grant_raw[i] = |map_raw[i];
    end
  end

  // Outputs are blanked combinationally while reset is high, even mid-packet.
  always_comb begin
    vc_mapping = '0;
    valid      = '0;
    grant_vc   = '0;
    if (!reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        vc_mapping[i] = map_raw[i];
        valid[i]      = grant_raw[i];
        grant_vc[i]   = grant_raw[i] ? s1_grant[i] : '0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Pointer update: only final grants advance a pointer. An input whose
  // stage-1 pick lost stage 2 keeps its pointer and retries the same VC.
  // -------------------------------------------------------------------------
  always_comb begin
    in_ptr_next  = in_ptr_reg;
    out_ptr_next = out_ptr_reg;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_raw[i]) begin
        in_ptr_next[i] = (s1_idx[i] == VW'(NUM_VCS - 1)) ? '0 : s1_idx[i] + VW'(1);
      end
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (s2_valid[o]) begin
        out_ptr_next[o] = (s2_idx[o] == PW'(NUM_PORTS - 1)) ? '0 : s2_idx[o] + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        in_ptr_reg[i]  <= '0;
        out_ptr_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        in_ptr_reg[i]  <= in_ptr_next[i];
        out_ptr_reg[i] <= out_ptr_next[i];
      end
    end
  end

endmodule
